// File: rtl/q_arb_pkg.sv
// q_arb_pkg: output-state encoding and default requester count for q_add_arbiter.
package q_arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    typedef enum logic {EMPTY, FULL} out_state_e;
endpackage

// File: rtl/q_fixed_pkg.sv
// q_fixed_pkg: shared fixed-point format (signed Q1.15) used by every adder client.
package q_fixed_pkg;
    localparam int FIXED_WIDTH  = 16;
    localparam int SCALE_FACTOR = 1 << (FIXED_WIDTH - 1);
    localparam int FIXED_MAX    = (1 << (FIXED_WIDTH - 1)) - 1;
    localparam int FIXED_MIN    = -(1 << (FIXED_WIDTH - 1));
endpackage

// File: rtl/q_add.sv
// q_add: saturating signed fixed-point adder.
module q_add
    import q_fixed_pkg::*;
(
    input  logic signed [FIXED_WIDTH-1:0] a,
    input  logic signed [FIXED_WIDTH-1:0] b,
    output logic signed [FIXED_WIDTH-1:0] sum
);
    logic signed [FIXED_WIDTH:0] s;
    assign s = a + b;
    // top two bits disagree only on overflow; the true sign picks the rail
    assign sum = (s[FIXED_WIDTH] ^ s[FIXED_WIDTH-1]) ? {s[FIXED_WIDTH], {(FIXED_WIDTH-1){~s[FIXED_WIDTH]}}}
                                                    : s[FIXED_WIDTH-1:0];
endmodule

// File: rtl/q_rr_arbiter.sv
// q_rr_arbiter: combinational round-robin grant, first requester at or after pointer wins.
module q_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);
    int idx;
    // scan farthest offset first so the nearest requester overwrites it
    always_comb begin
        grant = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(pointer) + k) % NUM_REQ;
            if (enable && req[idx]) grant = NUM_REQ'(1) << idx;
        end
    end
endmodule

// File: rtl/q_add_arbiter.sv
// q_add_arbiter: round-robin sharing of one saturating adder among NUM_REQ requesters,
// with a single registered response slot that can drain and refill in the same cycle.
module q_add_arbiter
    import q_fixed_pkg::*, q_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][FIXED_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][FIXED_WIDTH-1:0]   req_b,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic signed [FIXED_WIDTH-1:0]         rsp_result,
    output logic [ID_W-1:0]                       rsp_id
);
    out_state_e state, state_nxt;
    logic [ID_W-1:0] ptr, gnt_id;
    logic [NUM_REQ-1:0] grant;
    logic en, fire;
    logic signed [FIXED_WIDTH-1:0] sum;

    q_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req(req_valid), .pointer(ptr), .enable(en), .grant(grant)
    );

    q_add u_add (.a(req_a[gnt_id]), .b(req_b[gnt_id]), .sum(sum));

    assign req_ready = grant;
    assign fire = |grant;

    always_comb begin
        gnt_id = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant[k]) gnt_id = ID_W'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    end

    always_comb state_nxt = fire ? FULL : (rsp_ready ? EMPTY : state);

    // a full slot may only be refilled when it is being drained this cycle
    always_comb begin
        en = !rst && (state == EMPTY || rsp_ready);
        rsp_valid = state == FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            rsp_result <= '0;
            rsp_id <= '0;
        end else if (fire) begin
            ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
            rsp_result <= sum;
            rsp_id <= gnt_id;
        end
    end
endmodule

// File: tb/tb_q_add_arbiter.sv
// tb_q_add_arbiter: directed and randomized checks of q_add_arbiter against a
// cycle-level behavioural model (pointer, slot occupancy, saturated sum).
module tb_q_add_arbiter;
    import q_fixed_pkg::*;
    localparam int N = 4;

    logic clk = 0;
    logic rst;
    logic [N-1:0] req_valid, req_ready;
    logic [N-1:0][FIXED_WIDTH-1:0] req_a, req_b;
    logic rsp_valid, rsp_ready;
    logic signed [FIXED_WIDTH-1:0] rsp_result;
    logic [1:0] rsp_id;

    int n_vec = 0, n_bad = 0;
    int m_p = 0, m_id = 0;
    bit m_full = 0;
    logic [FIXED_WIDTH-1:0] m_res = '0;

    always #5 clk = ~clk;

    q_add_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id)
    );

    function automatic logic [FIXED_WIDTH-1:0] sat(logic [FIXED_WIDTH-1:0] a, logic [FIXED_WIDTH-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > FIXED_MAX) s = FIXED_MAX;
        if (s < FIXED_MIN) s = FIXED_MIN;
        return FIXED_WIDTH'(s);
    endfunction

    function automatic int pick();
        if (rst || (m_full && !rsp_ready)) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_p + k) % N]) return (m_p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick();
        return g < 0 ? '0 : N'(1) << g;
    endfunction

    task automatic tick(output int g);
        g = pick();
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_res = '0; m_id = 0; m_p = 0;
        end else if (g >= 0) begin
            m_full = 1; m_res = sat(req_a[g], req_b[g]); m_id = g; m_p = (g + 1) % N;
        end else if (rsp_ready) m_full = 0;
        #1;
    endtask

    task automatic test_reset();
        int g;
        rst = 1; req_valid = '1; rsp_ready = 1;
        for (int i = 0; i < N; i++) begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
        #1;
        n_vec++;
        if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        tick(g);
        n_vec++;
        if ({rsp_valid, rsp_result, rsp_id} !== '0) begin
            n_bad++; $display("FAIL reset_state: valid=%b result=%h id=%0d want all zero", rsp_valid, rsp_result, rsp_id);
        end
        rst = 0; req_valid = '0;
        tick(g);
    endtask

    task automatic test_single();
        int g;
        req_valid = 4'b0100; rsp_ready = 1;
        req_a[2] = 16'(SCALE_FACTOR / 2); req_b[2] = 16'(SCALE_FACTOR / 4);
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick(g);
        req_valid = '0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'(3 * SCALE_FACTOR / 4) || rsp_id !== 2'd2) begin
            n_bad++; $display("FAIL single_rsp: valid=%b result=%h id=%0d want 1 %h 2", rsp_valid, rsp_result, rsp_id, 16'(3 * SCALE_FACTOR / 4));
        end
        tick(g);
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_fairness();
        int g;
        rst = 1; tick(g); rst = 0;
        for (int i = 0; i < N; i++) begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
        req_valid = '1; rsp_ready = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_vec++;
            if (req_ready !== N'(1) << (c % N)) begin n_bad++; $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, N'(1) << (c % N)); end
            tick(g);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % N) || rsp_result !== sat(req_a[c % N], req_b[c % N])) begin
                n_bad++; $display("FAIL fair_rsp%0d: valid=%b id=%0d result=%h want 1 %0d %h", c, rsp_valid, rsp_id, rsp_result, c % N, sat(req_a[c % N], req_b[c % N]));
            end
        end
        req_valid = '0; tick(g);
    endtask

    task automatic test_saturation();
        int g;
        logic [FIXED_WIDTH-1:0] v;
        rsp_ready = 1;
        for (int s = 0; s < 2; s++) begin
            v = 16'(8 * SCALE_FACTOR / 10);
            if (s == 1) v = -v;
            req_a[1] = v; req_b[1] = v; req_valid = 4'b0010;
            tick(g);
            req_valid = '0;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'(s == 0 ? FIXED_MAX : FIXED_MIN)) begin
                n_bad++; $display("FAIL sat%0d: valid=%b result=%h want 1 %h", s, rsp_valid, rsp_result, 16'(s == 0 ? FIXED_MAX : FIXED_MIN));
            end
            tick(g);
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [FIXED_WIDTH-1:0] held;
        rsp_ready = 1; req_valid = 4'b0001;
        req_a[0] = 16'($urandom); req_b[0] = 16'($urandom);
        tick(g);
        held = rsp_result;
        req_valid = 4'b0110; rsp_ready = 0;
        for (int i = 1; i < 3; i++) begin req_a[i] = 16'($urandom); req_b[i] = 16'($urandom); end
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++;
            if (req_ready !== '0) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
            tick(g);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_id !== 2'd0) begin
                n_bad++; $display("FAIL bp_hold%0d: valid=%b result=%h id=%0d want 1 %h 0", c, rsp_valid, rsp_result, rsp_id, held);
            end
        end
        rsp_ready = 1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_refill_ready: got %b want 0010", req_ready); end
        tick(g);
        req_valid = '0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== sat(req_a[1], req_b[1])) begin
            n_bad++; $display("FAIL bp_refill_rsp: valid=%b id=%0d result=%h want 1 1 %h", rsp_valid, rsp_id, rsp_result, sat(req_a[1], req_b[1]));
        end
        tick(g);
    endtask

    task automatic test_reset_mid();
        int g;
        rsp_ready = 1; req_valid = 4'b0100;
        tick(g);
        req_valid = '0; rsp_ready = 0; rst = 1;
        tick(g);
        rst = 0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", rsp_valid); end
        req_valid = 4'b1010; rsp_ready = 1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_grant: got %b want 0010", req_ready); end
        tick(g);
        req_valid = '0;
        tick(g);
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_reemit: valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] pend;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1; req_a[i] = 16'($urandom); req_b[i] = 16'($urandom);
                end else if (pend[i] && $urandom_range(19) == 0) pend[i] = 0;
            end
            req_valid = pend;
            rsp_ready = $urandom_range(3) != 0;
            rst = $urandom_range(60) == 0;
            #1;
            n_vec++;
            if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL rand_ready%0d: got %b want %b", c, req_ready, exp_ready()); end
            tick(g);
            if (g >= 0) pend[g] = 0;
            n_vec++;
            if (rsp_valid !== m_full || (m_full && (rsp_result !== m_res || rsp_id !== 2'(m_id)))) begin
                n_bad++; $display("FAIL rand_rsp%0d: valid=%b result=%h id=%0d want %b %h %0d", c, rsp_valid, rsp_result, rsp_id, m_full, m_res, m_id);
            end
        end
        rst = 0; req_valid = '0;
    endtask

    initial begin
        req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_fairness();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/q_add_arbiter.md
Q_ADD_ARBITER -- requirements
Module: q_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters sharing one adder; legal range 2..8.
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), sets the width of the requester ID.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-007 Port req_ready, output, NUM_REQ bits: per-requester grant (accept) strobe.
REQ-008 Port req_a, input, NUM_REQ x FIXED_WIDTH, signed: per-requester operand a.
REQ-009 Port req_b, input, NUM_REQ x FIXED_WIDTH, signed: per-requester operand b.
REQ-010 Port rsp_valid, output, 1 bit: response register holds a result.
REQ-011 Port rsp_ready, input, 1 bit: downstream accepts the response.
REQ-012 Port rsp_result, output, FIXED_WIDTH, signed: saturated sum a+b.
REQ-013 Port rsp_id, output, ID_W bits: index of the requester that owns rsp_result.

Function
REQ-014 One q_add instance SHALL be shared; its operands SHALL be muxed from the granted requester.
REQ-015 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-016 req_ready SHALL be one-hot or zero, and SHALL be combinational from req_valid, the round-robin pointer and the output state.
REQ-017 A grant SHALL be issued only when the state is EMPTY, or when the state is FULL and rsp_ready is high in the same cycle (drain-and-refill).
REQ-018 The output FSM SHALL have two states: EMPTY->FULL on a grant; FULL->EMPTY on rsp_ready without a grant; FULL->FULL on rsp_ready with a grant; FULL holds while rsp_ready is low.
REQ-019 Latency SHALL be 1 cycle: a transfer at edge N SHALL present rsp_valid, rsp_result and rsp_id after edge N.
REQ-020 Sustained throughput SHALL be 1 result per cycle while rsp_ready is held high.
REQ-021 rsp_result and rsp_id SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-022 Arbitration SHALL be round-robin:
- Priority starts at pointer p and searches p, p+1, ... modulo NUM_REQ.
- After a grant to index i, p SHALL become (i+1) mod NUM_REQ.
- p SHALL be unchanged when no grant occurs.
REQ-023 rsp_result SHALL equal the q_add output: saturation to FIXED_MAX or FIXED_MIN, with no wrap-around.
REQ-024 Requesters SHALL hold req_valid and their operands until granted; a requester that withdraws before grant SHALL receive no response.

Reset
REQ-025 While rst is high at a clock edge, the following SHALL be set:
- state = EMPTY
- rsp_valid = 0
- rsp_result = 0
- rsp_id = 0
- p = 0
REQ-026 req_ready SHALL be all-zero during any cycle in which rst is high.
REQ-027 If rst is asserted while FULL, the pending response SHALL be discarded and not re-emitted.

Structure
REQ-028 FIXED_WIDTH, SCALE_FACTOR, FIXED_MAX and FIXED_MIN SHALL come from the shared fixed-point include.
REQ-029 A shared package q_arb_pkg SHALL hold the output-state enum (EMPTY, FULL) and the default NUM_REQ constant.
REQ-030 The round-robin grant logic SHALL be a sub-module q_rr_arbiter (inputs: req, pointer, enable; output: one-hot grant).

Verification
REQ-031 Single request: requester 2 sends a=SCALE_FACTOR/2, b=SCALE_FACTOR/4 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_result=3*SCALE_FACTOR/4, rsp_id=2.
REQ-032 Fairness: all 4 requesters hold req_valid for 8 cycles with rsp_ready=1 -> grant order is 0,1,2,3,0,1,2,3 and each rsp_id matches its operands.
REQ-033 Saturation: a=b=8*SCALE_FACTOR/10 -> rsp_result=FIXED_MAX; a=b=-(8*SCALE_FACTOR/10) -> rsp_result=FIXED_MIN.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles while FULL, with 2 requesters valid ->
- req_ready is all-zero throughout.
- rsp_result is stable throughout.
- After rsp_ready rises, the drain and the next grant occur in the same cycle.
REQ-035 Reset mid-operation: rst asserted for 1 cycle while FULL with rsp_ready=0 -> rsp_valid=0 next cycle, and the next grant goes to the lowest valid index (p=0).
